// File: rtl/alu_arbiter_if.sv
// Signal bundle between the two requesters, the arbiter and the shared ALU.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface alu_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [7:0]  req_sel;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [1:0]  resp_valid;
    logic [15:0] resp_z;
    logic [3:0]  alu_sel;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [15:0] alu_z;
    logic        busy;

    modport slave (
        input  req_valid, req_sel, req_a, req_b, alu_z,
        output req_ready, resp_valid, resp_z, alu_sel, alu_a, alu_b, busy
    );

    modport master (
        output req_valid, req_sel, req_a, req_b, alu_z,
        input  req_ready, resp_valid, resp_z, alu_sel, alu_a, alu_b, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter for two requesters sharing one fixed-latency ALU.
// One operation in flight: IDLE grants, WAIT covers the ALU latency, RESP pulses the result.
module alu_arbiter #(
    parameter int unsigned ALU_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] { IDLE, WAIT, RESP } state_e;

    state_e      state_q, state_d;
    logic        rr_ptr_q, rr_ptr_d;
    logic        owner_q, owner_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  alu_sel_q, alu_sel_d;
    logic [7:0]  alu_a_q, alu_a_d;
    logic [7:0]  alu_b_q, alu_b_d;
    logic [15:0] resp_z_q, resp_z_d;
    logic        grant;
    logic        accept;
    logic [1:0]  req_ready;
    logic [1:0]  resp_valid;

    // Both pending: rr_ptr decides; otherwise the single valid requester wins.
    assign grant  = (bus.req_valid == 2'b11) ? rr_ptr_q : bus.req_valid[1];
    // No handshake is offered while reset is asserted, so nothing can commit into a cleared FSM.
    assign accept = (state_q == IDLE) && (bus.req_valid != 2'b00) && !rst;

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        alu_sel_d  = alu_sel_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        resp_z_d   = resp_z_q;
        req_ready  = 2'b00;
        resp_valid = 2'b00;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    req_ready = grant ? 2'b10 : 2'b01;
                    owner_d   = grant;
                    rr_ptr_d  = ~grant;
                    cnt_d     = 4'(ALU_LAT);
                    alu_sel_d = grant ? bus.req_sel[7:4] : bus.req_sel[3:0];
                    alu_a_d   = grant ? bus.req_a[15:8]  : bus.req_a[7:0];
                    alu_b_d   = grant ? bus.req_b[15:8]  : bus.req_b[7:0];
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                // Counter runs ALU_LAT..0, so WAIT lasts ALU_LAT+1 cycles.
                if (cnt_q == 4'd0) begin
                    resp_z_d = bus.alu_z;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                resp_valid = owner_q ? 2'b10 : 2'b01;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so all of them sample pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_ptr_q  <= 1'b0;
            owner_q   <= 1'b0;
            cnt_q     <= 4'd0;
            alu_sel_q <= 4'd0;
            alu_a_q   <= 8'd0;
            alu_b_q   <= 8'd0;
            resp_z_q  <= 16'd0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            alu_sel_q <= alu_sel_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            resp_z_q  <= resp_z_d;
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = resp_valid;
    assign bus.resp_z     = resp_z_q;
    assign bus.alu_sel    = alu_sel_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.busy       = (state_q != IDLE);
endmodule
